dn_port_arbiter: RTL
====================

// Module: dn_port_arbiter
// PURPOSE
// - Owns the core's single ROM/RAM download port (dn_addr/dn_data/dn_wr) and the core reset.
// - Shares the port between two writers: HPS ioctl ROM download (index 0) and a high-score NVRAM restore requester.
// - Holds the core in reset from power-up, through each download, and for a settle period after it.
// - Sits between hps_io and williams2; replaces the direct ioctl->dn_* wiring.
// PARAMETERS
// - ADDR_W         18      dn_addr width; ROM image must fit in 2**ADDR_W bytes
// - HS_ADDR_W      10      high-score requester address width
// - HS_BASE        18'h3FC00  dn_addr of high-score byte 0
// - SETTLE_CYCLES  16      clk_sys cycles core_reset stays high after download end (>=1)
// PORTS
// - clk_sys         in   1        system clock (12 MHz domain)
// - reset           in   1        asynchronous, active-high
// - ioctl_download  in   1        HPS download active
// - ioctl_index     in   16       download index; only 0 is a ROM load
// - ioctl_wr        in   1        ioctl byte strobe
// - ioctl_addr      in   25       ioctl byte address
// - ioctl_dout      in   8        ioctl byte data
// - hs_req          in   1        high-score write request; held until hs_ack
// - hs_addr         in   HS_ADDR_W  high-score byte offset
// - hs_data         in   8        high-score byte
// - hs_ack          out  1        one-cycle pulse: hs byte issued
// - dn_addr         out  ADDR_W   download port address
// - dn_data         out  8        download port data
// - dn_wr           out  1        download port write strobe
// - core_reset      out  1        reset to williams2 (ORed with user reset at top)
// - rom_ready       out  1        high in RUN only
// - err_oversize    out  1        sticky: ioctl write beyond 2**ADDR_W
// - load_bytes      out  ADDR_W+1  bytes accepted in the last/current ROM load
// BEHAVIOUR
// - Reset values: dn_*=0, hs_ack=0, core_reset=1, rom_ready=0, err_oversize=0, load_bytes=0, state=IDLE.
// - rom_load = ioctl_download && ioctl_index==0. Other indexes never change state or drive dn_*.
// - FSM, registered:
//   - IDLE   -> LOAD on rom_load.
//   - LOAD   -> SETTLE when rom_load drops.
//   - SETTLE -> RUN after SETTLE_CYCLES cycles; -> LOAD if rom_load rises (counter cleared).
//   - RUN    -> LOAD on rom_load.
// - core_reset=1 in IDLE/LOAD/SETTLE, 0 in RUN. rom_ready = (state==RUN).
// - Entering LOAD clears load_bytes and err_oversize.
// - LOAD write path: ioctl_wr with ioctl_addr[24:ADDR_W]==0 produces next cycle:
//   dn_wr=1, dn_addr=ioctl_addr[ADDR_W-1:0], dn_data=ioctl_dout; load_bytes++.
//   - Out-of-range address: no dn_wr, err_oversize<=1.
// - HS path: accepted only in RUN with no ioctl_wr that cycle. Next cycle:
//   dn_wr=1, dn_addr=HS_BASE+hs_addr (mod 2**ADDR_W), dn_data=hs_data, hs_ack=1.
//   - Requester deasserts or changes hs_req after hs_ack. The arbiter does not re-ack while hs_ack is high
//     (minimum 2-cycle spacing per byte).
// - Priority: ioctl always wins. An hs_req pending in IDLE/LOAD/SETTLE stays un-acked and is served once RUN is reached.
// - dn_wr and hs_ack are single-cycle pulses; dn_addr/dn_data hold their last value when dn_wr=0.
// - Latency: 1 cycle from the accepted strobe to dn_wr.
// - Reset mid-LOAD: immediate return to IDLE and all outputs to reset values; a partial image is not marked ready.
// - load_bytes saturates at 2**ADDR_W.
// STRUCTURE
// - Package dn_arb_pkg: state enum {IDLE,LOAD,SETTLE,RUN}, ROM_INDEX=16'd0, mux-select enum {SEL_NONE,SEL_IOCTL,SEL_HS}.
// - One sub-module, settle_timer: load/clear input, done output, width $clog2(SETTLE_CYCLES+1).
// - Everything else (FSM, mux, counters) lives in the top.
// TESTING
// - Power-up: reset 5 cycles, no download -> core_reset=1, rom_ready=0, dn_wr never pulses.
// - ROM load idx0, 3 bytes @0,1,2 = A5,5A,FF -> 3 dn_wr pulses, each 1 cycle after ioctl_wr, data matching;
//   load_bytes=3; core_reset falls exactly SETTLE_CYCLES cycles after download drops.
// - Oversize: write at ioctl_addr=25'h40000 -> no dn_wr, err_oversize=1; cleared by next idx0 download start.
// - HS restore in RUN: hs_req, hs_addr=3, hs_data=42 -> dn_addr=18'h3FC03, dn_data=42, dn_wr=1, hs_ack=1 same cycle.
// - Contention: hs_req raised during LOAD -> no ack until RUN. Same-cycle ioctl_wr and hs_req in RUN (idx0 restart)
//   -> ioctl byte issued, hs stalls, core_reset=1.
// - Reset mid-LOAD after 2 bytes -> IDLE; load_bytes=0; rom_ready stays 0.
//   idx1 download -> no state change, no dn_wr.

Source files
------------

// File: rtl/dn_arb_pkg.sv
// dn_arb_pkg
// Shared types for the download-port arbiter: the arbiter state machine
// encoding, the download index that identifies a ROM image, and the select
// code that picks which writer owns the download port on a given cycle.
package dn_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        SEL_NONE  = 2'd0,
        SEL_IOCTL = 2'd1,
        SEL_HS    = 2'd2
    } arb_sel_t;

    localparam logic [15:0] ROM_INDEX = 16'd0;

endpackage

// File: rtl/dn_port_arbiter_settle_timer.sv
// settle_timer
// Counts how long the arbiter has been in its post-download settle phase.
// Ports:
//   clk    - clock
//   reset  - asynchronous active-high reset
//   clear  - hold the count at zero (asserted whenever not settling)
//   done   - high on the last settle cycle, i.e. after CYCLES-1 counted cycles
module settle_timer #(
    parameter int CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic done
);

    localparam int CNT_W = $clog2(CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] count_r;

    // Decode the terminal count; with CYCLES=1 this is true on the first settle cycle.
    always_comb begin
        done = (count_r == LAST);
    end

    // Settle cycle counter: cleared outside the settle phase, parks at the terminal value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (!done) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/dn_port_arbiter.sv
// dn_port_arbiter
// Owns the core's single ROM/RAM download port and the core reset. The port
// is shared between the HPS ioctl ROM download (index 0, always wins) and the
// high-score NVRAM restore requester (only served once the core is running).
// The core is held in reset from power-up, during each ROM download and for
// SETTLE_CYCLES cycles after it.
// Ports:
//   clk_sys, reset                      - clock, asynchronous active-high reset
//   ioctl_download/index/wr/addr/dout   - HPS download interface
//   hs_req/hs_addr/hs_data, hs_ack      - high-score restore handshake
//   dn_addr/dn_data/dn_wr               - download port towards the core
//   core_reset, rom_ready               - core reset and image-ready flag
//   err_oversize, load_bytes            - load diagnostics
module dn_port_arbiter
    import dn_arb_pkg::*;
#(
    parameter int                ADDR_W        = 18,
    parameter int                HS_ADDR_W     = 10,
    parameter logic [ADDR_W-1:0] HS_BASE       = 18'h3FC00,
    parameter int                SETTLE_CYCLES = 16
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 ioctl_download,
    input  logic [15:0]          ioctl_index,
    input  logic                 ioctl_wr,
    input  logic [24:0]          ioctl_addr,
    input  logic [7:0]           ioctl_dout,
    input  logic                 hs_req,
    input  logic [HS_ADDR_W-1:0] hs_addr,
    input  logic [7:0]           hs_data,
    output logic                 hs_ack,
    output logic [ADDR_W-1:0]    dn_addr,
    output logic [7:0]           dn_data,
    output logic                 dn_wr,
    output logic                 core_reset,
    output logic                 rom_ready,
    output logic                 err_oversize,
    output logic [ADDR_W:0]      load_bytes
);

    localparam logic [ADDR_W:0] LOAD_MAX = {1'b1, {ADDR_W{1'b0}}};

    arb_state_t          state_r;
    arb_state_t          next_s;
    arb_sel_t            sel_s;
    logic                rom_load_s;
    logic                in_range_s;
    logic                io_wr_s;
    logic                oversize_s;
    logic                hs_grant_s;
    logic                entering_load_s;
    logic                settle_done_s;
    logic [ADDR_W:0]     bytes_base_s;
    logic [ADDR_W-1:0]   hs_dn_addr_s;

    logic                hs_ack_r;
    logic [ADDR_W-1:0]   dn_addr_r;
    logic [7:0]          dn_data_r;
    logic                dn_wr_r;
    logic                core_reset_r;
    logic                rom_ready_r;
    logic                err_oversize_r;
    logic [ADDR_W:0]     load_bytes_r;

    settle_timer #(
        .CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk   (clk_sys),
        .reset (reset),
        .clear (state_r != SETTLE),
        .done  (settle_done_s)
    );

    // Request decode and port-owner selection; ioctl always takes precedence.
    // The high-score writer is also held off while a ROM download is asserted,
    // so no restore byte lands in an image that is about to be replaced.
    always_comb begin
        rom_load_s   = ioctl_download && (ioctl_index == ROM_INDEX);
        in_range_s   = (ioctl_addr[24:ADDR_W] == '0);
        io_wr_s      = rom_load_s && ioctl_wr;
        oversize_s   = io_wr_s && !in_range_s;
        hs_grant_s   = (state_r == RUN) && hs_req && !hs_ack_r && !ioctl_wr && !rom_load_s;
        hs_dn_addr_s = HS_BASE + {{(ADDR_W-HS_ADDR_W){1'b0}}, hs_addr};
        if (io_wr_s && in_range_s) begin
            sel_s = SEL_IOCTL;
        end else if (hs_grant_s) begin
            sel_s = SEL_HS;
        end else begin
            sel_s = SEL_NONE;
        end
    end

    // Next-state logic for the reset/load sequencer.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE:    next_s = rom_load_s ? LOAD : IDLE;
            LOAD:    next_s = rom_load_s ? LOAD : SETTLE;
            SETTLE: begin
                if (rom_load_s) begin
                    next_s = LOAD;
                end else if (settle_done_s) begin
                    next_s = RUN;
                end else begin
                    next_s = SETTLE;
                end
            end
            RUN:     next_s = rom_load_s ? LOAD : RUN;
            default: next_s = IDLE;
        endcase
    end

    // A byte accepted on the cycle LOAD is entered counts towards the new load.
    always_comb begin
        entering_load_s = (next_s == LOAD) && (state_r != LOAD);
        if (entering_load_s) begin
            bytes_base_s = '0;
        end else begin
            bytes_base_s = load_bytes_r;
        end
    end

    // State register.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Registered port, handshake and status outputs (decoded from next state).
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dn_wr_r        <= 1'b0;
            dn_addr_r      <= '0;
            dn_data_r      <= 8'h00;
            hs_ack_r       <= 1'b0;
            core_reset_r   <= 1'b1;
            rom_ready_r    <= 1'b0;
            err_oversize_r <= 1'b0;
            load_bytes_r   <= '0;
        end else begin
            dn_wr_r      <= (sel_s != SEL_NONE);
            hs_ack_r     <= (sel_s == SEL_HS);
            core_reset_r <= (next_s != RUN);
            rom_ready_r  <= (next_s == RUN);
            case (sel_s)
                SEL_IOCTL: begin
                    dn_addr_r <= ioctl_addr[ADDR_W-1:0];
                    dn_data_r <= ioctl_dout;
                end
                SEL_HS: begin
                    dn_addr_r <= hs_dn_addr_s;
                    dn_data_r <= hs_data;
                end
                default: begin
                    dn_addr_r <= dn_addr_r;
                    dn_data_r <= dn_data_r;
                end
            endcase
            if (entering_load_s) begin
                err_oversize_r <= oversize_s;
            end else begin
                err_oversize_r <= err_oversize_r | oversize_s;
            end
            if ((sel_s == SEL_IOCTL) && (bytes_base_s != LOAD_MAX)) begin
                load_bytes_r <= bytes_base_s + (ADDR_W+1)'(1);
            end else begin
                load_bytes_r <= bytes_base_s;
            end
        end
    end

    assign hs_ack       = hs_ack_r;
    assign dn_addr      = dn_addr_r;
    assign dn_data      = dn_data_r;
    assign dn_wr        = dn_wr_r;
    assign core_reset   = core_reset_r;
    assign rom_ready    = rom_ready_r;
    assign err_oversize = err_oversize_r;
    assign load_bytes   = load_bytes_r;

endmodule
